// File: rtl/jtdd_gfx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtdd_gfx_arb                                                 |
// | Description : Graphics ROM arbiter. Shares one 16-bit SDRAM read port      |
// |               among the character, scroll and object layers. Each layer    |
// |               owns a one-entry cache (address, data, valid) so a repeated  |
// |               address is served combinationally with no memory access.     |
// | Ports       : clk, rst_n (synchronous, active-low)                         |
// |               char_/scr_/obj_ cs, addr (in)  data, ok (out)                |
// |               mem_req, mem_addr (out)  mem_ack, mem_rdy, mem_data (in)     |
// | Option      : JTDD_ARB_RR_EN defined -> round-robin grant order            |
// |               (char -> scr -> obj -> char); undefined -> fixed priority    |
// |               char > scr > obj.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module jtdd_gfx_arb #(
    parameter int          CHAR_AW     = 15,
    parameter int          SCR_AW      = 17,
    parameter int          OBJ_AW      = 18,
    parameter logic [21:0] CHAR_OFFSET = 22'h00_0000,
    parameter logic [21:0] SCR_OFFSET  = 22'h08_0000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h10_0000
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               char_cs,
    input  logic [CHAR_AW-1:0] char_addr,
    output logic [15:0]        char_data,
    output logic               char_ok,

    input  logic               scr_cs,
    input  logic [SCR_AW-1:0]  scr_addr,
    output logic [15:0]        scr_data,
    output logic               scr_ok,

    input  logic               obj_cs,
    input  logic [OBJ_AW-1:0]  obj_addr,
    output logic [15:0]        obj_data,
    output logic               obj_ok,

    output logic               mem_req,
    output logic [21:0]        mem_addr,
    input  logic               mem_ack,
    input  logic               mem_rdy,
    input  logic [15:0]        mem_data
);

    // Widest requester address; the latched address register uses this width
    // so one register serves every requester.
    localparam int c_lat_w = (CHAR_AW > SCR_AW) ?
                             ((CHAR_AW > OBJ_AW) ? CHAR_AW : OBJ_AW) :
                             ((SCR_AW  > OBJ_AW) ? SCR_AW  : OBJ_AW);

    localparam logic [1:0] c_id_char = 2'd0;
    localparam logic [1:0] c_id_scr  = 2'd1;
    localparam logic [1:0] c_id_obj  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [1:0]           r_gnt;
    logic [c_lat_w-1:0]   r_lat;
    logic                 r_mem_req;
    logic [21:0]          r_mem_addr;

    logic [CHAR_AW-1:0]   r_char_last;
    logic [15:0]          r_char_data;
    logic                 r_char_valid;
    logic [SCR_AW-1:0]    r_scr_last;
    logic [15:0]          r_scr_data;
    logic                 r_scr_valid;
    logic [OBJ_AW-1:0]    r_obj_last;
    logic [15:0]          r_obj_data;
    logic                 r_obj_valid;

`ifdef JTDD_ARB_RR_EN
    logic [1:0]           r_last;
`endif

    logic [2:0]           w_pend;
    logic                 w_any;
    logic [1:0]           w_sel;
    logic [c_lat_w-1:0]   w_char_ext;
    logic [c_lat_w-1:0]   w_scr_ext;
    logic [c_lat_w-1:0]   w_obj_ext;
    logic [c_lat_w-1:0]   w_sel_ext;
    logic [21:0]          w_sel_22;
    logic [21:0]          w_sel_off;
    logic                 w_done;

    // Hit detection is purely combinational so a repeated address is served
    // in the same cycle it is presented.
    assign char_ok = char_cs && r_char_valid && (char_addr == r_char_last);
    assign scr_ok  = scr_cs  && r_scr_valid  && (scr_addr  == r_scr_last);
    assign obj_ok  = obj_cs  && r_obj_valid  && (obj_addr  == r_obj_last);

    assign char_data = r_char_data;
    assign scr_data  = r_scr_data;
    assign obj_data  = r_obj_data;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;

    assign w_pend = {obj_cs && !obj_ok, scr_cs && !scr_ok, char_cs && !char_ok};
    assign w_any  = |w_pend;

    // Grant selection
    always_comb begin
        w_sel = c_id_char;
`ifdef JTDD_ARB_RR_EN
        // Search begins with the requester following the last grant.
        case (r_last)
            c_id_char: begin
                if      (w_pend[1]) w_sel = c_id_scr;
                else if (w_pend[2]) w_sel = c_id_obj;
                else                w_sel = c_id_char;
            end
            c_id_scr: begin
                if      (w_pend[2]) w_sel = c_id_obj;
                else if (w_pend[0]) w_sel = c_id_char;
                else if (w_pend[1]) w_sel = c_id_scr;
                else                w_sel = c_id_char;
            end
            default: begin
                if      (w_pend[0]) w_sel = c_id_char;
                else if (w_pend[1]) w_sel = c_id_scr;
                else if (w_pend[2]) w_sel = c_id_obj;
                else                w_sel = c_id_char;
            end
        endcase
`else
        if      (w_pend[0]) w_sel = c_id_char;
        else if (w_pend[1]) w_sel = c_id_scr;
        else if (w_pend[2]) w_sel = c_id_obj;
        else                w_sel = c_id_char;
`endif
    end

    // Zero-extend each requester address to the common latched width, then
    // pick the selected one together with its SDRAM base.
    always_comb begin
        w_char_ext                = '0;
        w_char_ext[CHAR_AW-1:0]   = char_addr;
        w_scr_ext                 = '0;
        w_scr_ext[SCR_AW-1:0]     = scr_addr;
        w_obj_ext                 = '0;
        w_obj_ext[OBJ_AW-1:0]     = obj_addr;
        case (w_sel)
            c_id_scr: begin
                w_sel_ext = w_scr_ext;
                w_sel_off = SCR_OFFSET;
            end
            c_id_obj: begin
                w_sel_ext = w_obj_ext;
                w_sel_off = OBJ_OFFSET;
            end
            default: begin
                w_sel_ext = w_char_ext;
                w_sel_off = CHAR_OFFSET;
            end
        endcase
        w_sel_22                = '0;
        w_sel_22[c_lat_w-1:0]   = w_sel_ext;
    end

    // Data arrives either in the same cycle as the acknowledge or later in WAIT.
    assign w_done = ((r_state == S_REQ) && mem_ack && mem_rdy) ||
                    ((r_state == S_WAIT) && mem_rdy);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gnt        <= c_id_char;
            r_lat        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_char_last  <= '0;
            r_char_data  <= '0;
            r_char_valid <= 1'b0;
            r_scr_last   <= '0;
            r_scr_data   <= '0;
            r_scr_valid  <= 1'b0;
            r_obj_last   <= '0;
            r_obj_data   <= '0;
            r_obj_valid  <= 1'b0;
`ifdef JTDD_ARB_RR_EN
            r_last       <= c_id_char;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_sel;
                        r_lat      <= w_sel_ext;
                        r_mem_req  <= 1'b1;
                        // 22-bit sum wraps without carry-out.
                        r_mem_addr <= w_sel_off + w_sel_22;
                        r_state    <= S_REQ;
`ifdef JTDD_ARB_RR_EN
                        r_last     <= w_sel;
`endif
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= mem_rdy ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rdy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase

            // The cache keeps the address latched at issue time, so an
            // address change during the transaction still reads as a miss.
            if (w_done) begin
                case (r_gnt)
                    c_id_scr: begin
                        r_scr_last  <= r_lat[SCR_AW-1:0];
                        r_scr_data  <= mem_data;
                        r_scr_valid <= 1'b1;
                    end
                    c_id_obj: begin
                        r_obj_last  <= r_lat[OBJ_AW-1:0];
                        r_obj_data  <= mem_data;
                        r_obj_valid <= 1'b1;
                    end
                    default: begin
                        r_char_last  <= r_lat[CHAR_AW-1:0];
                        r_char_data  <= mem_data;
                        r_char_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
